// File: rtl/rs_en_pkg.sv
// Shared types for the clocked gated SR latch: state encoding, command decode and sync-depth limit.
// The optional forbid flags (macro RS_EN_FORBID_FLAG_EN) need nothing from this package.
package rs_en_pkg;

  typedef enum logic [1:0] {
    CLR    = 2'b00,
    SET    = 2'b01,
    FORBID = 2'b11
  } rs_state_t;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SETC = 2'b01,
    CLRC = 2'b10,
    BOTH = 2'b11
  } rs_cmd_t;

  localparam int SYNC_MAX = 3;

  // A closed enable gates every request into HOLD.
  function automatic rs_cmd_t decode_cmd(input logic c, input logic s, input logic r);
    rs_cmd_t cmd;
    cmd = HOLD;
    if (c) begin
      case ({s, r})
        2'b10:   cmd = SETC;
        2'b01:   cmd = CLRC;
        2'b11:   cmd = BOTH;
        default: cmd = HOLD;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/rs_en_sync.sv
// Per-bit flop chain that brings asynchronous control inputs into the clk domain.
// STAGES = 0 makes it a plain wire for inputs that are already synchronous.
module rs_en_sync #(
  parameter int STAGES = 0,
  parameter int WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_chain
      logic [WIDTH-1:0] r_chain [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
          r_chain[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
      end

      assign o_q = r_chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/rs_en_latch.sv
// Single-clock gated SR latch with true/complement outputs and the NAND-latch S=R=1 output state.
// Macro RS_EN_FORBID_FLAG_EN adds the forbid / forbid_seen status outputs.
module rs_en_latch
  import rs_en_pkg::*;
#(
  parameter int   SYNC_STAGES = 0,
  parameter logic INIT_Q      = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      C,
  input  logic      S,
  input  logic      R,
  output logic      Q,
  output logic      Qn,
  output rs_state_t o_dbg_state
`ifdef RS_EN_FORBID_FLAG_EN
  ,
  output logic      forbid,
  output logic      forbid_seen
`endif
);

  localparam int SYNC_EFF = (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;

  // Valid/ready does not apply: C/S/R are level commands sampled on every clk edge.
  logic [2:0] w_csr;
  logic       w_c;
  logic       w_s;
  logic       w_r;
  rs_cmd_t    w_cmd;
  rs_state_t  w_state_nxt;
  logic       w_lv_nxt;

  rs_state_t  r_state;
  logic       r_last_valid;
  logic       r_q;
  logic       r_qn;

  rs_en_sync #(
    .STAGES (SYNC_EFF),
    .WIDTH  (3)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({C, S, R}),
    .o_q (w_csr)
  );

  assign w_c = w_csr[2];
  assign w_s = w_csr[1];
  assign w_r = w_csr[0];

  always_comb begin
    w_cmd       = decode_cmd(w_c, w_s, w_r);
    w_state_nxt = CLR;
    w_lv_nxt    = r_last_valid;
    case (w_cmd)
      SETC: begin
        w_state_nxt = SET;
        w_lv_nxt    = 1'b1;
      end
      CLRC: begin
        w_state_nxt = CLR;
        w_lv_nxt    = 1'b0;
      end
      BOTH: w_state_nxt = FORBID;
      default: begin
        // Holding in FORBID is not allowed: fall back to the last legal value.
        case (r_state)
          SET:     w_state_nxt = SET;
          FORBID:  w_state_nxt = r_last_valid ? SET : CLR;
          default: w_state_nxt = CLR;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT_Q ? SET : CLR;
      r_last_valid <= INIT_Q;
      r_q          <= INIT_Q;
      r_qn         <= ~INIT_Q;
    end else begin
      r_state      <= w_state_nxt;
      r_last_valid <= w_lv_nxt;
      r_q          <= (w_state_nxt == SET) || (w_state_nxt == FORBID);
      r_qn         <= (w_state_nxt == CLR) || (w_state_nxt == FORBID);
    end
  end

  assign Q           = r_q;
  assign Qn          = r_qn;
  assign o_dbg_state = r_state;

`ifdef RS_EN_FORBID_FLAG_EN
  logic r_forbid;
  logic r_forbid_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_forbid      <= 1'b0;
      r_forbid_seen <= 1'b0;
    end else begin
      r_forbid      <= (w_state_nxt == FORBID);
      r_forbid_seen <= r_forbid_seen | (w_state_nxt == FORBID);
    end
  end

  assign forbid      = r_forbid;
  assign forbid_seen = r_forbid_seen;
`endif

endmodule

// File: tb/tb_rs_en_latch.sv
// Directed bench for rs_en_latch: three instances (sync 0/init 0, sync 0/init 1, sync 2/init 0) on shared stimulus.
// Flag checks are compiled in only when RS_EN_FORBID_FLAG_EN is defined.
module tb_rs_en_latch;
  import rs_en_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c = 1'b0;
  logic s = 1'b0;
  logic r = 1'b0;

  logic       q0, qn0, q1, qn1, q2, qn2;
  logic [1:0] st0, st1, st2;
  int         n_checks = 0;
  int         n_pass   = 0;

`ifdef RS_EN_FORBID_FLAG_EN
  logic fb0, fs0, fb1, fs1, fb2, fs2;
`endif

  always #50 clk = ~clk;

  rs_en_latch #(.SYNC_STAGES(0), .INIT_Q(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .C(c), .S(s), .R(r), .Q(q0), .Qn(qn0), .o_dbg_state(st0)
`ifdef RS_EN_FORBID_FLAG_EN
    , .forbid(fb0), .forbid_seen(fs0)
`endif
  );

  rs_en_latch #(.SYNC_STAGES(0), .INIT_Q(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .C(c), .S(s), .R(r), .Q(q1), .Qn(qn1), .o_dbg_state(st1)
`ifdef RS_EN_FORBID_FLAG_EN
    , .forbid(fb1), .forbid_seen(fs1)
`endif
  );

  rs_en_latch #(.SYNC_STAGES(2), .INIT_Q(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .C(c), .S(s), .R(r), .Q(q2), .Qn(qn2), .o_dbg_state(st2)
`ifdef RS_EN_FORBID_FLAG_EN
    , .forbid(fb2), .forbid_seen(fs2)
`endif
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cc, input logic ss, input logic rr);
    c = cc;
    s = ss;
    r = rr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    step();
    step();
    n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL reset_q0 got %b exp 01", {q0, qn0}); else n_pass++;
    n_checks++; if (st0 !== CLR) $display("FAIL reset_st0 got %b exp %b", st0, CLR); else n_pass++;
    n_checks++; if ({q1, qn1} !== 2'b10) $display("FAIL reset_q1 got %b exp 10", {q1, qn1}); else n_pass++;
    n_checks++; if ({q2, qn2} !== 2'b01) $display("FAIL reset_q2 got %b exp 01", {q2, qn2}); else n_pass++;
`ifdef RS_EN_FORBID_FLAG_EN
    n_checks++; if ({fb0, fs0} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {fb0, fs0}); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_set_hold();
    drive(1, 1, 0);
    step();
    n_checks++; if ({q0, qn0} !== 2'b10) $display("FAIL set_q0 got %b exp 10", {q0, qn0}); else n_pass++;
    n_checks++; if (st0 !== SET) $display("FAIL set_st0 got %b exp %b", st0, SET); else n_pass++;
    drive(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if ({q0, qn0} !== 2'b10) $display("FAIL set_hold_q0[%0d] got %b exp 10", i, {q0, qn0}); else n_pass++;
    end
  endtask

  task automatic test_clear_hold();
    drive(1, 0, 1);
    step();
    n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL clr_q0 got %b exp 01", {q0, qn0}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, (i % 2 == 0), 0);
      step();
      n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL clr_hold_q0[%0d] got %b exp 01", i, {q0, qn0}); else n_pass++;
    end
  endtask

  task automatic test_forbid();
    drive(1, 1, 0);
    step();
    drive(1, 1, 1);
    step();
    n_checks++; if ({q0, qn0} !== 2'b11) $display("FAIL forbid_q0 got %b exp 11", {q0, qn0}); else n_pass++;
    n_checks++; if (st0 !== FORBID) $display("FAIL forbid_st0 got %b exp %b", st0, FORBID); else n_pass++;
`ifdef RS_EN_FORBID_FLAG_EN
    n_checks++; if ({fb0, fs0} !== 2'b11) $display("FAIL forbid_flags got %b exp 11", {fb0, fs0}); else n_pass++;
`endif
    drive(0, 1, 1);
    step();
    n_checks++; if ({q0, qn0} !== 2'b10) $display("FAIL forbid_resolve1_q0 got %b exp 10", {q0, qn0}); else n_pass++;
`ifdef RS_EN_FORBID_FLAG_EN
    n_checks++; if ({fb0, fs0} !== 2'b01) $display("FAIL forbid_sticky got %b exp 01", {fb0, fs0}); else n_pass++;
`endif
    // Enter FORBID from CLR, then release with C=1,S=R=0: must fall back to 0.
    drive(1, 0, 1);
    step();
    drive(1, 1, 1);
    step();
    n_checks++; if ({q0, qn0} !== 2'b11) $display("FAIL forbid2_q0 got %b exp 11", {q0, qn0}); else n_pass++;
    drive(1, 0, 0);
    step();
    n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL forbid_resolve0_q0 got %b exp 01", {q0, qn0}); else n_pass++;
  endtask

  task automatic test_idempotent();
    drive(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      c = (i % 2 == 0);
      step();
      n_checks++; if ({q0, qn0} !== 2'b10) $display("FAIL idem_q0[%0d] got %b exp 10", i, {q0, qn0}); else n_pass++;
    end
  endtask

  task automatic test_reset_forbid();
    drive(1, 1, 1);
    step();
    n_checks++; if ({q0, qn0, q1, qn1} !== 4'b1111) $display("FAIL rf_pre got %b exp 1111", {q0, qn0, q1, qn1}); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL rf_q0 got %b exp 01", {q0, qn0}); else n_pass++;
    n_checks++; if ({q1, qn1} !== 2'b10) $display("FAIL rf_q1 got %b exp 10", {q1, qn1}); else n_pass++;
    n_checks++; if (st1 !== SET) $display("FAIL rf_st1 got %b exp %b", st1, SET); else n_pass++;
`ifdef RS_EN_FORBID_FLAG_EN
    n_checks++; if ({fb0, fs0} !== 2'b00) $display("FAIL rf_flags got %b exp 00", {fb0, fs0}); else n_pass++;
`endif
    rst = 1'b0;
    step();
    n_checks++; if ({q0, qn0, q1, qn1} !== 4'b1111) $display("FAIL rf_reenter got %b exp 1111", {q0, qn0, q1, qn1}); else n_pass++;
    drive(0, 1, 1);
    step();
    n_checks++; if ({q0, qn0} !== 2'b01) $display("FAIL rf_lv_q0 got %b exp 01", {q0, qn0}); else n_pass++;
    n_checks++; if ({q1, qn1} !== 2'b10) $display("FAIL rf_lv_q1 got %b exp 10", {q1, qn1}); else n_pass++;
  endtask

  task automatic test_sync_latency();
    rst = 1'b1;
    drive(0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
    drive(1, 1, 0);
    step();
    n_checks++; if (q0 !== 1'b1) $display("FAIL lat_q0_k1 got %b exp 1", q0); else n_pass++;
    n_checks++; if ({q2, qn2} !== 2'b01) $display("FAIL lat_q2_k1 got %b exp 01", {q2, qn2}); else n_pass++;
    step();
    n_checks++; if ({q2, qn2} !== 2'b01) $display("FAIL lat_q2_k2 got %b exp 01", {q2, qn2}); else n_pass++;
    step();
    n_checks++; if ({q2, qn2} !== 2'b10) $display("FAIL lat_q2_k3 got %b exp 10", {q2, qn2}); else n_pass++;
    n_checks++; if (st2 !== SET) $display("FAIL lat_st2 got %b exp %b", st2, SET); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_set_hold();
    test_clear_hold();
    test_forbid();
    test_idempotent();
    test_reset_forbid();
    test_sync_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
